// File: rtl/i8080_bus_pkg.sv
// Shared definitions for the 8080 bus responder: status word bit positions,
// machine-cycle classification and responder FSM states.
package i8080_bus_pkg;

    localparam int STAT_INTA  = 0;
    localparam int STAT_WO_N  = 1;
    localparam int STAT_STACK = 2;
    localparam int STAT_HLTA  = 3;
    localparam int STAT_OUT   = 4;
    localparam int STAT_M1    = 5;
    localparam int STAT_INP   = 6;
    localparam int STAT_MEMR  = 7;

    localparam logic [7:0] RST7_OPCODE = 8'hFF;

    typedef enum logic [2:0] {
        CYC_NONE,
        CYC_MEMRD,
        CYC_MEMWR,
        CYC_IORD,
        CYC_IOWR,
        CYC_INTA
    } cycle_type_t;

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_WAIT,
        RESP_XFER
    } resp_state_t;

    // A halt acknowledge also carries MEMR, so it is filtered before the read
    // check; an interrupt acknowledge taken while halted still counts as INTA.
    function automatic cycle_type_t decode_cycle(input logic [7:0] status);
        if (status[STAT_HLTA] && !status[STAT_INTA]) return CYC_NONE;
        if (status[STAT_MEMR])                       return CYC_MEMRD;
        if (status[STAT_INTA])                       return CYC_INTA;
        if (status[STAT_INP])                        return CYC_IORD;
        if (status[STAT_OUT])                        return CYC_IOWR;
        if (!status[STAT_WO_N])                      return CYC_MEMWR;
        return CYC_NONE;
    endfunction

    function automatic logic is_read_cycle(input cycle_type_t t);
        return (t == CYC_MEMRD) || (t == CYC_IORD) || (t == CYC_INTA);
    endfunction

    function automatic logic is_write_cycle(input cycle_type_t t);
        return (t == CYC_MEMWR) || (t == CYC_IOWR);
    endfunction

endpackage

// File: rtl/resp_ram.sv
// Single-port synchronous byte RAM with one-cycle read latency; contents are
// not reset.
module resp_ram #(
    parameter int AW = 12
) (
    input  logic          clk50M_i,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk50M_i) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/i8080_bus_responder.sv
// Target-side responder for 8080 machine cycles: local RAM, wait-state READY
// generation, INTA vector and optional I/O ports (I8080_RESP_IO_PORTS_EN).
module i8080_bus_responder
    import i8080_bus_pkg::*;
#(
    parameter int         MEM_AW      = 12,
    parameter int         WAIT_STATES = 1,
    parameter logic [7:0] RST_OPCODE  = RST7_OPCODE
) (
    input  logic        clk50M_i,
    input  logic        rst_ni,
    input  logic [15:0] addr_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        data_oe_o,
    input  logic        sync_i,
    input  logic        dbin_i,
    input  logic        wr_ni,
    output logic        ready_o,
    output logic [7:0]  io_out_o,
    input  logic [7:0]  io_in_i
);

    localparam bit         HAS_WAIT  = WAIT_STATES > 0;
    localparam logic [3:0] WAIT_LOAD = 4'(HAS_WAIT ? WAIT_STATES - 1 : 0);

    resp_state_t       state_q, state_d;
    cycle_type_t       cyc_type, sync_type, entry_type;
    logic [7:0]        status_q, data_q, ram_rdata;
    logic [15:0]       addr_q, entry_addr;
    logic [3:0]        cnt_q;
    logic              written_q, dbin_q, src_ram_q;
    logic              in_xfer, dbin_fall, wr_fire, enter_xfer, ram_we;
    logic [MEM_AW-1:0] ram_addr;

    function automatic logic is_mapped(input logic [15:0] a);
        return (a >> MEM_AW) == 16'd0;
    endfunction

    // A new sync overrides whatever cycle is in flight, so the entry-side
    // type/address come straight from the bus during the sync clock.
    assign sync_type  = decode_cycle(data_i);
    assign cyc_type   = decode_cycle(status_q);
    assign entry_type = sync_i ? sync_type : cyc_type;
    assign entry_addr = sync_i ? addr_i : addr_q;

    assign in_xfer    = state_q == RESP_XFER;
    assign dbin_fall  = dbin_q & ~dbin_i;
    assign wr_fire    = in_xfer && is_write_cycle(cyc_type) && !written_q && !wr_ni && !sync_i;
    assign enter_xfer = (state_d == RESP_XFER) && (!in_xfer || sync_i);
    assign ram_we     = wr_fire && (cyc_type == CYC_MEMWR) && is_mapped(addr_q);
    assign ram_addr   = entry_addr[MEM_AW-1:0];

    resp_ram #(.AW(MEM_AW)) u_ram (
        .clk50M_i (clk50M_i),
        .we       (ram_we),
        .addr     (ram_addr),
        .wdata    (data_i),
        .rdata    (ram_rdata)
    );

    always_ff @(posedge clk50M_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RESP_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (sync_i) begin
            if (sync_type == CYC_NONE) state_d = RESP_IDLE;
            else                       state_d = HAS_WAIT ? RESP_WAIT : RESP_XFER;
        end else begin
            case (state_q)
                RESP_IDLE: ;
                RESP_WAIT: if (cnt_q == 4'd0) state_d = RESP_XFER;
                RESP_XFER: begin
                    if (is_read_cycle(cyc_type) ? dbin_fall : (written_q && wr_ni))
                        state_d = RESP_IDLE;
                end
                default:   state_d = RESP_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o   = state_q != RESP_WAIT;
        data_oe_o = in_xfer && is_read_cycle(cyc_type) && dbin_i;
        data_o    = src_ram_q ? ram_rdata : data_q;
    end

    always_ff @(posedge clk50M_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q  <= 8'h00;
            addr_q    <= 16'h0000;
            cnt_q     <= 4'd0;
            written_q <= 1'b0;
            dbin_q    <= 1'b0;
        end else begin
            dbin_q <= dbin_i;
            if (sync_i) begin
                status_q  <= data_i;
                addr_q    <= addr_i;
                cnt_q     <= WAIT_LOAD;
                written_q <= 1'b0;
            end else begin
                if (state_q == RESP_WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                if (wr_fire) written_q <= 1'b1;
            end
        end
    end

    // Read-data source is chosen once, on the clock that enters XFER.
    always_ff @(posedge clk50M_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_ram_q <= 1'b0;
            data_q    <= 8'h00;
        end else if (enter_xfer) begin
            src_ram_q <= 1'b0;
            data_q    <= 8'hFF;
            case (entry_type)
                CYC_MEMRD: src_ram_q <= is_mapped(entry_addr);
                CYC_INTA:  data_q    <= RST_OPCODE;
`ifdef I8080_RESP_IO_PORTS_EN
                CYC_IORD:  data_q    <= io_in_i;
`endif
                default:   ;
            endcase
        end
    end

`ifdef I8080_RESP_IO_PORTS_EN
    logic [7:0] io_out_q;

    always_ff @(posedge clk50M_i or negedge rst_ni) begin
        if (!rst_ni)                                 io_out_q <= 8'h00;
        else if (wr_fire && cyc_type == CYC_IOWR)    io_out_q <= data_i;
    end

    assign io_out_o = io_out_q;
`else
    logic unused_io_in;

    assign unused_io_in = ^io_in_i;
    assign io_out_o     = 8'h00;
`endif

endmodule

// File: tb/tb_i8080_bus_responder.sv
// Bench for i8080_bus_responder: three instances (0, 1 and 3 wait states),
// a cycle-level bus model checked every clock, plus directed literal checks.
module tb_i8080_bus_responder;

    localparam int ND     = 3;
    localparam int MEM_AW = 12;

`ifdef I8080_RESP_IO_PORTS_EN
    localparam logic [7:0] EXP_IO_OUT = 8'h3C;
    localparam logic [7:0] EXP_IN     = 8'h5A;
`else
    localparam logic [7:0] EXP_IO_OUT = 8'h00;
    localparam logic [7:0] EXP_IN     = 8'hFF;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr   [ND];
    logic [7:0]  din    [ND];
    logic        sync   [ND];
    logic        dbin   [ND];
    logic        wr_n   [ND];
    logic [7:0]  io_in  [ND];
    logic [7:0]  dout   [ND];
    logic        oe     [ND];
    logic        rdy    [ND];
    logic [7:0]  io_out [ND];

    int vectors = 0;
    int errors  = 0;

    // Model state
    logic [7:0]  mem_m    [ND][4096];
    int          since    [ND];
    logic [7:0]  stat_m   [ND];
    logic [15:0] addr_m   [ND];
    bit          wrote    [ND];
    logic [7:0]  io_out_m [ND];

    always #5 clk = ~clk;

    i8080_bus_responder #(.MEM_AW(MEM_AW), .WAIT_STATES(1), .RST_OPCODE(8'hFF)) u_dut0 (
        .clk50M_i(clk), .rst_ni(rst_n), .addr_i(addr[0]), .data_i(din[0]),
        .data_o(dout[0]), .data_oe_o(oe[0]), .sync_i(sync[0]), .dbin_i(dbin[0]),
        .wr_ni(wr_n[0]), .ready_o(rdy[0]), .io_out_o(io_out[0]), .io_in_i(io_in[0]));

    i8080_bus_responder #(.MEM_AW(MEM_AW), .WAIT_STATES(0), .RST_OPCODE(8'hFF)) u_dut1 (
        .clk50M_i(clk), .rst_ni(rst_n), .addr_i(addr[1]), .data_i(din[1]),
        .data_o(dout[1]), .data_oe_o(oe[1]), .sync_i(sync[1]), .dbin_i(dbin[1]),
        .wr_ni(wr_n[1]), .ready_o(rdy[1]), .io_out_o(io_out[1]), .io_in_i(io_in[1]));

    i8080_bus_responder #(.MEM_AW(MEM_AW), .WAIT_STATES(3), .RST_OPCODE(8'hFF)) u_dut2 (
        .clk50M_i(clk), .rst_ni(rst_n), .addr_i(addr[2]), .data_i(din[2]),
        .data_o(dout[2]), .data_oe_o(oe[2]), .sync_i(sync[2]), .dbin_i(dbin[2]),
        .wr_ni(wr_n[2]), .ready_o(rdy[2]), .io_out_o(io_out[2]), .io_in_i(io_in[2]));

    function automatic int ws_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    // 0 none, 1 mem read, 2 mem write, 3 io read, 4 io write, 5 inta
    function automatic int cyc_kind(input logic [7:0] s);
        if (s[3] && !s[0]) return 0;
        if (s[7])          return 1;
        if (s[0])          return 5;
        if (s[6])          return 3;
        if (s[4])          return 4;
        if (!s[1])         return 2;
        return 0;
    endfunction

    function automatic logic [7:0] exp_byte(input int d, input int k);
        logic [15:0] a;
        a = addr_m[d];
        case (k)
            1: return (a[15:12] == 4'h0) ? mem_m[d][a[11:0]] : 8'hFF;
`ifdef I8080_RESP_IO_PORTS_EN
            3: return io_in[d];
`else
            3: return 8'hFF;
`endif
            default: return 8'hFF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle-level model: ready low for N clocks after sync, then a transfer
    // phase where reads drive while DBIN is high and the first low WR_n writes.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (!rst_n) begin
                    chk($sformatf("reset ready_o[%0d]", d), {7'd0, rdy[d]}, 8'h01);
                    chk($sformatf("reset data_oe_o[%0d]", d), {7'd0, oe[d]}, 8'h00);
                    chk($sformatf("reset data_o[%0d]", d), dout[d], 8'h00);
                    chk($sformatf("reset io_out_o[%0d]", d), io_out[d], 8'h00);
                    since[d]    = 1000;
                    stat_m[d]   = 8'h02;
                    wrote[d]    = 1'b0;
                    io_out_m[d] = 8'h00;
                end else begin
                    int k;
                    bit xfer, rd, exp_rdy, exp_oe;
                    k = cyc_kind(stat_m[d]);
                    if (since[d] < 1000) since[d]++;
                    exp_rdy = !(k != 0 && since[d] >= 1 && since[d] <= ws_of(d));
                    xfer    = (k != 0) && (since[d] > ws_of(d));
                    rd      = (k == 1) || (k == 3) || (k == 5);
                    exp_oe  = xfer && rd && dbin[d];
                    chk($sformatf("ready_o[%0d]", d), {7'd0, rdy[d]}, {7'd0, exp_rdy});
                    chk($sformatf("data_oe_o[%0d]", d), {7'd0, oe[d]}, {7'd0, exp_oe});
                    chk($sformatf("io_out_o[%0d]", d), io_out[d], io_out_m[d]);
                    if (exp_oe) chk($sformatf("data_o[%0d]", d), dout[d], exp_byte(d, k));
                    if (xfer && (k == 2 || k == 4) && !wrote[d] && !wr_n[d] && !sync[d]) begin
                        wrote[d] = 1'b1;
                        if (k == 2 && addr_m[d][15:12] == 4'h0) mem_m[d][addr_m[d][11:0]] = din[d];
`ifdef I8080_RESP_IO_PORTS_EN
                        if (k == 4) io_out_m[d] = din[d];
`endif
                    end
                    if (sync[d]) begin
                        since[d]  = 0;
                        stat_m[d] = din[d];
                        addr_m[d] = addr[d];
                        wrote[d]  = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) begin
            vectors++;
            errors++;
            $display("FAIL ready timeout[%0d]: got 0 expected 1", d);
        end
    endtask

    task automatic bus_read(input int d, input logic [7:0] st, input logic [15:0] a,
                            input bit with_wr, output logic [7:0] got);
        @(posedge clk); #1;
        sync[d] = 1'b1; din[d] = st; addr[d] = a;
        @(posedge clk); #1;
        sync[d] = 1'b0; din[d] = 8'h00; dbin[d] = 1'b1;
        if (with_wr) wr_n[d] = 1'b0;
        wait_ready(d);
        got = dout[d];
        @(posedge clk); #1;
        dbin[d] = 1'b0; wr_n[d] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input int d, input logic [7:0] st, input logic [15:0] a,
                             input logic [7:0] dat, input int hold, input logic [7:0] dat2);
        @(posedge clk); #1;
        sync[d] = 1'b1; din[d] = st; addr[d] = a;
        @(posedge clk); #1;
        sync[d] = 1'b0; din[d] = dat; wr_n[d] = 1'b0;
        wait_ready(d);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            din[d] = dat2;
        end
        @(posedge clk); #1;
        wr_n[d] = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] got;
        for (int d = 0; d < ND; d++) begin
            sync[d] = 1'b0; dbin[d] = 1'b0; wr_n[d] = 1'b1;
            din[d] = 8'h00; addr[d] = 16'h0000; io_in[d] = 8'h5A;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lit reset ready_o", {7'd0, rdy[0]}, 8'h01);
        chk("lit reset data_oe_o", {7'd0, oe[0]}, 8'h00);
        chk("lit reset io_out_o", io_out[0], 8'h00);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // one wait state: basic write/read, decode boundaries
        bus_write(0, 8'h00, 16'h0000, 8'h12, 1, 8'h12);
        bus_write(0, 8'h00, 16'h0010, 8'hA5, 1, 8'hA5);
        bus_read(0, 8'h82, 16'h0010, 1'b0, got);  chk("lit memrd 0010", got, 8'hA5);
        bus_read(0, 8'hA2, 16'h8000, 1'b0, got);  chk("lit m1 unmapped 8000", got, 8'hFF);
        bus_write(0, 8'h00, 16'h8000, 8'h55, 1, 8'h55);
        bus_read(0, 8'hA2, 16'h0000, 1'b0, got);  chk("lit m1 0000 intact", got, 8'h12);
        bus_write(0, 8'h00, 16'h0FFF, 8'hC3, 1, 8'hC3);
        bus_read(0, 8'h82, 16'h0FFF, 1'b0, got);  chk("lit memrd 0FFF", got, 8'hC3);
        bus_read(0, 8'h82, 16'hFFFF, 1'b0, got);  chk("lit memrd FFFF", got, 8'hFF);
        bus_read(0, 8'h23, 16'h0010, 1'b0, got);  chk("lit inta", got, 8'hFF);
        bus_write(0, 8'h04, 16'h0040, 8'h4E, 1, 8'h4E);
        bus_read(0, 8'h86, 16'h0040, 1'b0, got);  chk("lit stack rd", got, 8'h4E);

        // halt acknowledge is ignored
        @(posedge clk); #1;
        sync[0] = 1'b1; din[0] = 8'h8A; addr[0] = 16'h0000;
        @(posedge clk); #1;
        sync[0] = 1'b0; din[0] = 8'h00;
        @(negedge clk);
        chk("lit hlta ready_o", {7'd0, rdy[0]}, 8'h01);
        repeat (2) @(posedge clk); #1;

        // I/O ports
        bus_write(0, 8'h10, 16'h0707, 8'h3C, 1, 8'h3C);
        chk("lit io_out_o", io_out[0], EXP_IO_OUT);
        bus_read(0, 8'h42, 16'h0707, 1'b0, got);  chk("lit io in", got, EXP_IN);

        // reset during the XFER of a write loses the write
        bus_write(0, 8'h00, 16'h0030, 8'h66, 1, 8'h66);
        @(posedge clk); #1;
        sync[0] = 1'b1; din[0] = 8'h00; addr[0] = 16'h0030;
        @(posedge clk); #1;
        sync[0] = 1'b0; din[0] = 8'h99;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("lit rst ready_o", {7'd0, rdy[0]}, 8'h01);
        chk("lit rst data_oe_o", {7'd0, oe[0]}, 8'h00);
        chk("lit rst io_out_o", io_out[0], 8'h00);
        @(posedge clk); #1;
        wr_n[0] = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        wr_n[0] = 1'b1;
        @(posedge clk); #1;
        bus_read(0, 8'h82, 16'h0030, 1'b0, got);  chk("lit rst write lost", got, 8'h66);

        // zero wait states: single write despite long WR_n, read ignores WR_n
        bus_write(1, 8'h00, 16'h0100, 8'h21, 4, 8'hDE);
        bus_read(1, 8'h82, 16'h0100, 1'b0, got);  chk("lit ws0 single write", got, 8'h21);
        bus_read(1, 8'h82, 16'h0100, 1'b1, got);  chk("lit ws0 rd with wr", got, 8'h21);
        bus_read(1, 8'h82, 16'h0100, 1'b0, got);  chk("lit ws0 rd after", got, 8'h21);

        // three wait states: single write, abort in WAIT
        bus_write(2, 8'h00, 16'h0200, 8'hE7, 4, 8'h18);
        bus_read(2, 8'h82, 16'h0200, 1'b0, got);  chk("lit ws3 single write", got, 8'hE7);
        bus_write(2, 8'h00, 16'h0020, 8'h77, 1, 8'h77);
        @(posedge clk); #1;
        sync[2] = 1'b1; din[2] = 8'h00; addr[2] = 16'h0020;
        @(posedge clk); #1;
        sync[2] = 1'b0; din[2] = 8'h11; wr_n[2] = 1'b0;
        @(posedge clk); #1;
        wr_n[2] = 1'b1;
        bus_read(2, 8'h82, 16'h0020, 1'b0, got);  chk("lit ws3 abort", got, 8'h77);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i8080_bus_responder.md
Name: i8080_bus_responder

Overview:
- Target-side block that answers the CPU's external 8080 bus machine cycles: memory read, memory write, opcode fetch (M1), stack read/write, I/O IN/OUT and interrupt acknowledge.
- Contains a local synchronous RAM and a wait-state generator that drives READY.
- Sits between the CPU bus pins (address bus, data bus, SYNC/DBIN/WR_n) and the system clock and reset, and acts as the CPU's program/data memory during bring-up.

Parameters:
- MEM_AW, 12, RAM address width. Depth is 2^MEM_AW bytes, mapped at 16'h0000 upward.
- WAIT_STATES, 1, READY-low cycles inserted per machine cycle, 0..15.
- RST_OPCODE, 8'hFF, byte returned on an INTA read (RST 7).

Ports:
- clk50M_i  in  1  system clock; all logic is on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- addr_i  in  16  CPU address bus.
- data_i  in  8  CPU-driven data (write and OUT cycles).
- data_o  out  8  responder-driven data.
- data_oe_o  out  1  responder is driving the data bus.
- sync_i  in  1  high for one cycle at T1; data_i carries the status word.
- dbin_i  in  1  CPU data-in strobe.
- wr_ni  in  1  CPU write strobe, active low.
- ready_o  out  1  high when the cycle may complete.
- io_out_o  out  8  last OUT data (see optional feature).
- io_in_i  in  8  IN data source (see optional feature).

Behaviour:
- Reset values: data_o=0, data_oe_o=0, ready_o=1, io_out_o=0, FSM=IDLE, latched status=0.
- Status bits, from the package: D0 INTA, D1 WO_n, D2 STACK, D3 HLTA, D4 OUT, D5 M1, D6 INP, D7 MEMR.
- Cycle type on sync_i:
  - Latch status=data_i and addr=addr_i.
  - Type is MEMRD if MEMR, INTA if INTA, IORD if INP, IOWR if OUT, else MEMWR when WO_n=0.
  - HLTA-only cycles are ignored; stay in IDLE.
- FSM states: IDLE, WAIT, XFER.
  - IDLE to WAIT on sync_i when WAIT_STATES>0; IDLE to XFER directly when WAIT_STATES=0.
  - WAIT: ready_o=0 and the counter loads WAIT_STATES-1. Decrement each cycle; at 0 go to XFER.
  - XFER: ready_o=1.
  - Read types: the RAM read is issued when entering WAIT, or at the sync cycle if there are 0 waits. data_o is registered and valid from the first XFER cycle. data_oe_o=dbin_i while in XFER. XFER to IDLE on the falling edge of dbin_i.
  - Write types: exactly one RAM write per cycle, on the first XFER clock that samples wr_ni=0. XFER to IDLE when wr_ni returns high after that write.
- Ready while idle: ready_o=0 from the sync cycle onward in WAIT, and ready_o=1 in IDLE.
- Latency: with N=WAIT_STATES, ready_o rises N cycles after the sync_i cycle.
- Address decode:
  - addr[15:MEM_AW] nonzero means unmapped.
  - Unmapped read returns 8'hFF; unmapped write is dropped.
- INTA read: data_o=RST_OPCODE, with no RAM access.
- Boundaries:
  - sync_i asserted while not IDLE: abort the current cycle without writing and restart with the new status.
  - dbin_i and wr_ni=0 together in XFER: the cycle type decides which one is honoured; the other is ignored.
  - Address 16'hFFFF and wrap-around: no special handling; decode only.
  - Asynchronous reset mid-cycle: go to IDLE immediately with reset outputs; any pending write is lost.

Optional Feature:
- Macro: I8080_RESP_IO_PORTS_EN.
- When defined:
  - IOWR latches data_i into io_out_o on the write clock.
  - IORD returns io_in_i, sampled on entry to XFER.
  - The port address is addr[7:0] and is not decoded; every port aliases.
- When undefined:
  - IORD returns 8'hFF.
  - IOWR is dropped.
  - io_out_o is held at 0 and io_in_i is unused.

Decomposition:
- Package i8080_bus_pkg:
  - status bit index constants;
  - cycle_type enum (MEMRD, MEMWR, IORD, IOWR, INTA, NONE);
  - resp_state enum (IDLE, WAIT, XFER);
  - RST7 opcode constant.
- Sub-module resp_ram:
  - single-port synchronous RAM, parameter AW;
  - ports clk50M_i, we, addr, wdata, rdata;
  - one-cycle read latency;
  - no reset of contents.

Test Plan:
- WAIT_STATES=1: MEMWR to 16'h0010 with data 8'hA5, then MEMRD of 16'h0010 -> ready_o low for exactly 1 cycle after each sync_i; the read drives data_o=8'hA5 with data_oe_o=1 only while dbin_i=1.
- M1 fetch from unmapped 16'h8000 -> data_o=8'hFF; a write to 16'h8000 leaves RAM unchanged (read back 16'h0000 region is intact).
- INTA cycle (status 8'h23) -> data_o=8'hFF (RST 7); the RAM is not read.
- WAIT_STATES=0 vs 3 -> ready_o stays high vs goes low for exactly 3 cycles; wr_ni held low for 4 cycles writes the RAM once (write-count probe = 1).
- sync_i reasserted during WAIT, and rst_ni pulsed low during XFER of a write -> the aborted write does not modify RAM; after reset ready_o=1, data_oe_o=0 and io_out_o=0.
- With I8080_RESP_IO_PORTS_EN: OUT 8'h3C to port 8'h07 gives io_out_o=8'h3C; IN with io_in_i=8'h5A gives data_o=8'h5A. Without the macro: IN returns 8'hFF and io_out_o stays 0.
